// File: rtl/ysyx_220066_lsu.sv
// Load/store unit: one memory op per transaction over a 64-bit aligned req/gnt/rvalid bus,
// returning extended load data or store completion with an error code.
module ysyx_220066_lsu #(
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              MemRd,
   input  logic              MemWr,
   input  logic [2:0]        MemOp,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [63:0]       mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_rdata,
   output logic [1:0]        out_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   logic [7:0]  cnt_r;
   logic        rd_r;
   logic        wr_r;
   logic [2:0]  op_r;
   logic [2:0]  off_r;
   logic        illegal_s;
   logic        misalign_s;

   function automatic logic [63:0] store_lanes(input logic [1:0] sz, input logic [63:0] d);
      case (sz)
         2'b00:   return {8{d[7:0]}};
         2'b01:   return {4{d[15:0]}};
         2'b10:   return {2{d[31:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [7:0] store_mask(input logic [1:0] sz, input logic [2:0] off);
      case (sz)
         2'b00:   return 8'h01 << off;
         2'b01:   return 8'h03 << off;
         2'b10:   return 8'h0F << off;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [63:0] load_extract(input logic [2:0] op, input logic [2:0] off,
                                                input logic [63:0] d);
      logic [63:0] lane;
      lane = d >> {off, 3'b000};
      case (op)
         3'b000:  return {{56{lane[7]}}, lane[7:0]};
         3'b001:  return {{48{lane[15]}}, lane[15:0]};
         3'b010:  return {{32{lane[31]}}, lane[31:0]};
         3'b011:  return lane;
         3'b100:  return {56'h0, lane[7:0]};
         3'b101:  return {48'h0, lane[15:0]};
         3'b110:  return {32'h0, lane[31:0]};
         default: return 64'h0;
      endcase
   endfunction

   // Classify the presented op; legality takes priority over alignment.
   always_comb begin
      illegal_s  = (MemRd & MemWr) | (MemRd & (MemOp == 3'b111)) | (MemWr & MemOp[2]);
      misalign_s = 1'b0;
      case (MemOp[1:0])
         2'b01:   misalign_s = addr[0];
         2'b10:   misalign_s = (addr[1:0] != 2'b00);
         2'b11:   misalign_s = (addr[2:0] != 3'b000);
         default: misalign_s = 1'b0;
      endcase
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 8'd0;
         rd_r      <= 1'b0;
         wr_r      <= 1'b0;
         op_r      <= 3'b000;
         off_r     <= 3'b000;
         in_ready  <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 64'h0;
         mem_wmask <= 8'h00;
         out_valid <= 1'b0;
         out_rdata <= 64'h0;
         out_err   <= 2'b00;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  rd_r     <= MemRd;
                  wr_r     <= MemWr;
                  op_r     <= MemOp;
                  off_r    <= addr[2:0];
                  in_ready <= 1'b0;
                  if (illegal_s) begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                     out_rdata <= 64'h0;
                     out_err   <= 2'b10;
                  end else if (misalign_s && (MemRd || MemWr)) begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                     out_rdata <= 64'h0;
                     out_err   <= 2'b01;
                  end else if (!MemRd && !MemWr) begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                     out_rdata <= 64'h0;
                     out_err   <= 2'b00;
                  end else begin
                     state_r   <= REQ;
                     cnt_r     <= 8'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= MemWr;
                     mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                     mem_wdata <= MemWr ? store_lanes(MemOp[1:0], wdata) : 64'h0;
                     mem_wmask <= MemWr ? store_mask(MemOp[1:0], addr[2:0]) : 8'h00;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  cnt_r   <= cnt_r + 8'd1;
                  if (wr_r) begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                     out_rdata <= 64'h0;
                     out_err   <= 2'b00;
                  end else begin
                     state_r <= WAIT;
                  end
               end else if (cnt_r >= CNT_LAST) begin
                  mem_req   <= 1'b0;
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  out_rdata <= 64'h0;
                  out_err   <= 2'b11;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            WAIT: begin
               if (mem_rvalid && rd_r) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  out_rdata <= load_extract(op_r, off_r, mem_rdata);
                  out_err   <= 2'b00;
               end else if (cnt_r >= CNT_LAST) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  out_rdata <= 64'h0;
                  out_err   <= 2'b11;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  out_rdata <= 64'h0;
                  out_err   <= 2'b00;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               in_ready  <= 1'b1;
               mem_req   <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Directed scoreboard bench for ysyx_220066_lsu (TIMEOUT=4 instance).
module tb_ysyx_220066_lsu;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, MemRd, MemWr;
   logic [2:0]  MemOp;
   logic [63:0] addr, wdata;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_gnt, mem_rvalid;
   logic [63:0] mem_rdata;
   logic        out_valid, out_ready;
   logic [63:0] out_rdata;
   logic [1:0]  out_err;

   typedef struct {
      logic [63:0] rdata;
      logic [1:0]  err;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_err    = 0;

   ysyx_220066_lsu #(.ADDR_W(64), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp), .addr(addr), .wdata(wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata(out_rdata), .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] wd);
      in_valid = 1'b1; MemRd = rd; MemWr = wr; MemOp = op; addr = a; wdata = wd;
      @(negedge clk);
      in_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = 3'b000;
      addr = 64'h0; wdata = 64'h0;
   endtask

   task automatic take_result(input string tag);
      exp_t e;
      chk({tag, "_valid"}, out_valid, 64'd1);
      chk({tag, "_sb"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_rdata"}, out_rdata, e.rdata);
         chk({tag, "_err"}, 64'(out_err), 64'(e.err));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 64'd0);
      chk({tag, "_in_ready"}, in_ready, 64'd1);
   endtask

   task automatic do_load(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] rd, input logic [63:0] exp);
      sb_q.push_back('{rdata: exp, err: 2'b00});
      issue(1'b1, 1'b0, op, a, 64'h0);
      chk({tag, "_req"}, mem_req, 64'd1);
      chk({tag, "_we"}, mem_we, 64'd0);
      chk({tag, "_addr"}, mem_addr, a & ~64'h7);
      chk({tag, "_early"}, out_valid, 64'd0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk({tag, "_req_drop"}, mem_req, 64'd0);
      chk({tag, "_early2"}, out_valid, 64'd0);
      mem_rvalid = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 64'h0;
      take_result(tag);
   endtask

   task automatic do_store(input string tag, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] ew, input logic [7:0] em);
      sb_q.push_back('{rdata: 64'h0, err: 2'b00});
      issue(1'b0, 1'b1, op, a, wd);
      chk({tag, "_req"}, mem_req, 64'd1);
      chk({tag, "_we"}, mem_we, 64'd1);
      chk({tag, "_addr"}, mem_addr, a & ~64'h7);
      chk({tag, "_wdata"}, mem_wdata, ew);
      chk({tag, "_wmask"}, 64'(mem_wmask), 64'(em));
      chk({tag, "_early"}, out_valid, 64'd0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk({tag, "_req_drop"}, mem_req, 64'd0);
      take_result(tag);
   endtask

   task automatic do_err(input string tag, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [63:0] a, input logic [1:0] err);
      sb_q.push_back('{rdata: 64'h0, err: err});
      issue(rd, wr, op, a, 64'hDEAD_BEEF_0000_0001);
      chk({tag, "_noreq"}, mem_req, 64'd0);
      take_result(tag);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = 3'b000;
      addr = 64'h0; wdata = 64'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = 64'h0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 64'd1);
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_mem_req", mem_req, 64'd0);
      chk("rst_rdata", out_rdata, 64'h0);
      chk("rst_err", 64'(out_err), 64'd0);
      chk("rst_wmask", 64'(mem_wmask), 64'd0);

      // Loads: sign/zero extension at various lanes.
      do_load("lb", 3'b000, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      do_load("lbu", 3'b100, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080);
      do_load("lh", 3'b001, 64'h8000_0002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
      do_load("lwu", 3'b110, 64'h8000_0004, 64'h9ABC_DEF0_0000_0000, 64'h0000_0000_9ABC_DEF0);
      do_load("lw", 3'b010, 64'h8000_0004, 64'h9ABC_DEF0_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0);
      do_load("ld", 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);

      // Stores: lane replication and byte masks.
      do_store("sh", 3'b001, 64'h8000_0006, 64'h0000_0000_0000_1234, 64'h1234_1234_1234_1234, 8'hC0);
      do_store("sb", 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'hABAB_ABAB_ABAB_ABAB, 8'h08);
      do_store("sw", 3'b010, 64'h8000_0004, 64'h0000_0000_CAFE_F00D, 64'hCAFE_F00D_CAFE_F00D, 8'hF0);
      do_store("sd", 3'b011, 64'h8000_0008, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 8'hFF);

      // Error and no-op paths.
      do_err("lw_mis", 1'b1, 1'b0, 3'b010, 64'h8000_0002, 2'b01);
      do_err("ld_mis", 1'b1, 1'b0, 3'b011, 64'h8000_0004, 2'b01);
      do_err("ld_111", 1'b1, 1'b0, 3'b111, 64'h8000_0000, 2'b10);
      do_err("rdwr", 1'b1, 1'b1, 3'b011, 64'h8000_0000, 2'b10);
      do_err("st_op4", 1'b0, 1'b1, 3'b100, 64'h8000_0000, 2'b10);
      do_err("noop", 1'b0, 1'b0, 3'b011, 64'h8000_0001, 2'b00);

      // Timeout: grant withheld, request held for exactly TIMEOUT cycles.
      sb_q.push_back('{rdata: 64'h0, err: 2'b11});
      issue(1'b1, 1'b0, 3'b010, 64'h8000_0010, 64'h0);
      n = 0;
      while (mem_req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_req_cycles", 64'(n), 64'd4);
      chk("tmo_valid", out_valid, 64'd1);
      mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 64'h0;
      chk("tmo_late_rdata", out_rdata, 64'h0);
      take_result("tmo");
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("idle_rvalid_ignored", out_valid, 64'd0);

      // Back-pressure in DONE: result held stable while out_ready is low.
      sb_q.push_back('{rdata: 64'h1122_3344_5566_7788, err: 2'b00});
      issue(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'h0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mem_rdata = 64'(i) * 64'h0101_0101;
         chk("stall_valid", out_valid, 64'd1);
         chk("stall_rdata", out_rdata, 64'h1122_3344_5566_7788);
         chk("stall_in_ready", in_ready, 64'd0);
         @(negedge clk);
      end
      mem_rdata = 64'h0;
      take_result("stall");
      sb_q.push_back('{rdata: 64'h0, err: 2'b00});
      issue(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
      take_result("next_accept");

      // Reset while waiting for read data.
      issue(1'b1, 1'b0, 3'b011, 64'h8000_0030, 64'h0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("wrst_in_ready", in_ready, 64'd1);
      chk("wrst_valid", out_valid, 64'd0);
      chk("wrst_req", mem_req, 64'd0);
      mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 64'h0;
      chk("wrst_late_rvalid", out_valid, 64'd0);
      @(negedge clk);
      chk("wrst_late_rvalid2", out_valid, 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ysyx_220066_lsu.md
Name: ysyx_220066_lsu

Overview:
- Load/store unit at the consumer end of the decode stage's memory-control outputs (MemRd, MemWr, MemOp = funct3).
- Takes one memory operation per transaction with an effective address and store data from EX.
- Drives a 64-bit, 8-byte-aligned data-memory bus with a req/gnt/rvalid handshake.
- Returns sign/zero-extended load data, or store completion, to WB with a valid/ready handshake, plus an error code.

Parameters:
ADDR_W, 64, width of effective and bus addresses
TIMEOUT, 255, max cycles spent in REQ+WAIT before aborting with timeout error (8-bit counter, 1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX presents an operation
in_ready  out  1  LSU can accept (high only in IDLE)
MemRd  in  1  load
MemWr  in  1  store
MemOp  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
addr  in  ADDR_W  effective address
wdata  in  64  store data (low bytes significant)
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  {addr[ADDR_W-1:3],3'b000}
mem_wdata  out  64  lane-replicated store data
mem_wmask  out  8  byte enables
mem_gnt  in  1  bus accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  64  read data
out_valid  out  1  result available
out_ready  in  1  WB consumes result
out_rdata  out  64  extended load data; 0 for stores and errors
out_err  out  2  00 ok, 01 misaligned, 10 illegal MemOp/both Rd+Wr, 11 timeout

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state IDLE; all outputs 0 except in_ready=1; timeout counter 0; captured op/addr/data cleared.
- IDLE: in_ready=1. On in_valid, capture MemRd, MemWr, MemOp, addr, wdata and classify:
  - Illegal: MemRd&MemWr; load MemOp=111; store MemOp[2]=1. -> DONE, err=10.
  - Misaligned (checked after legality): h/hu addr[0]!=0; w/wu addr[1:0]!=0; d addr[2:0]!=0. -> DONE, err=01.
  - Neither MemRd nor MemWr: no-op -> DONE, err=00, rdata=0.
  - Otherwise -> REQ.
  - Error and no-op paths never raise mem_req.
- REQ: mem_req=1; mem_we, mem_addr, mem_wdata, mem_wmask held stable from the registered capture until mem_gnt. On gnt: store -> DONE; load -> WAIT. mem_req drops the cycle after gnt.
- WAIT: mem_req=0. On mem_rvalid, register extracted data -> DONE.
- Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. Reaching TIMEOUT without gnt/rvalid -> DONE, err=11, rdata=0.
- DONE: out_valid=1; out_rdata and out_err stable until out_ready. On out_ready -> IDLE. The next op is accepted no earlier than the cycle after the handshake, so there is no back-to-back acceptance.
- Latency: store with gnt in its first REQ cycle gives out_valid 2 cycles after acceptance. Load with gnt plus rvalid on the next cycle gives 3 cycles.
- Store lanes, off=addr[2:0]:
  - b: wdata={8{wdata[7:0]}}, mask=8'h01<<off
  - h: {4{wdata[15:0]}}, 8'h03<<off
  - w: {2{wdata[31:0]}}, 8'h0F<<off
  - d: wdata, 8'hFF
- Load extract: lane = mem_rdata >> (8*off); sign-extend for b/h/w, zero-extend for bu/hu/wu; d passes through.
- mem_rvalid/mem_gnt outside REQ/WAIT are ignored.
- rst in any state: next edge returns to IDLE with the reset values above and mem_req=0. A pending bus response is dropped.
- Width: all address arithmetic is ADDR_W bits. The offset uses addr[2:0] only.

Test Plan:
- lb at addr 0x80000005, mem_rdata 0x0000_8000_0000_0000 (byte5=0x80), gnt same cycle, rvalid next -> out_rdata 0xFFFF_FFFF_FFFF_FF80, err 00, out_valid 3 cycles after acceptance; lbu same stimulus -> 0x0000_0000_0000_0080.
- sh addr 0x80000006, wdata 0x1234 -> mem_addr 0x80000000, mem_wmask 0xC0, mem_wdata 0x1234_1234_1234_1234, mem_we=1; out_valid 2 cycles after acceptance, rdata 0.
- lw addr 0x80000002 -> no mem_req ever, out_valid next cycle, err 01; ld with MemOp 111 -> err 10; MemRd&MemWr -> err 10.
- Load with mem_gnt withheld, TIMEOUT=4 -> mem_req high 4 cycles, then out_valid with err 11; a late rvalid afterwards is ignored.
- out_ready held low 5 cycles in DONE -> out_valid/out_rdata stable, in_ready 0; release -> IDLE, next op accepted the following cycle.
- rst asserted in WAIT -> next cycle IDLE, in_ready 1, out_valid 0, mem_req 0; rvalid arriving after reset produces no output.
